uart_buffered: RTL and testbench

Parametrised async serial UART with a 16x oversampling receiver, configurable data width, optional parity, one or two stop bits, and a FIFO on each direction. It runs on one system clock and generates its own baud timing with an internal divider. It replaces the single-register UART behind the console/TTY device logic. The CPU side keeps the level req / pulsed ack handshake.

---
 rtl/uart_buffered.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered.sv
// Buffered UART: 16x oversampling RX, parity/stop options, TX and RX FIFOs.
// Ports: clk/reset; tx_req/tx_ack/tx_data/tx_full/tx_idle CPU write side;
// rx_req/rx_ack/rx_data/rx_empty CPU read side; sticky rx_*_err/rx_over_run
// flags cleared by err_clr; rx_in (async) and tx_out serial lines.
module uart_buffered #(
    parameter int DATA_BITS = 8,
    parameter int DIV       = 27,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_req,
    output logic                 tx_ack,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic                 tx_idle,
    input  logic                 rx_req,
    output logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_over_run,
    input  logic                 err_clr,
    input  logic                 rx_in,
    output logic                 tx_out
);
    localparam int DEPTH = 2 ** FIFO_LOG2;
    localparam int TXW   = $clog2(16 * DIV);
    localparam int DVW   = $clog2(DIV);
    localparam int PW    = FIFO_LOG2 + 1;
    localparam logic [TXW-1:0] TX_LAST = TXW'(16 * DIV - 1);
    localparam logic [DVW-1:0] DV_LAST = DVW'(DIV - 1);
    localparam logic [2:0] DB_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] SB_LAST = 3'(STOP_BITS - 1);
    localparam logic HAS_PAR = (PARITY != 0);
    localparam logic ODD     = (PARITY == 1);

    typedef enum logic [1:0] {HS_WAIT, HS_ACK, HS_HOLD} hs_e;
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
    } ser_e;

    hs_e txh_q, txh_d, rxh_q, rxh_d;
    ser_e txs_q, txs_d, rxs_q, rxs_d;
    logic [DATA_BITS-1:0] tx_mem [DEPTH];
    logic [DATA_BITS-1:0] rx_mem [DEPTH];
    logic [PW-1:0] txw_q, txw_d, txr_q, txr_d;
    logic [PW-1:0] rxw_q, rxw_d, rxr_q, rxr_d;
    logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d, tx_head, rx_head;
    logic tx_par_q, tx_par_d, tx_out_q, tx_out_d;
    logic rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [DVW-1:0] div_q, div_d;
    logic [3:0] rx_tc_q, rx_tc_d;
    logic rx_pb_q, rx_pb_d;
    logic fe_q, fe_d, pe_q, pe_d, or_q, or_d;
    logic tx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop;
    logic tick, mid, load, set_fe, set_pe, set_or;

    always_ff @(posedge clk) begin
        if (reset) begin
            txh_q     <= HS_WAIT;
            rxh_q     <= HS_WAIT;
            txs_q     <= S_IDLE;
            rxs_q     <= S_IDLE;
            txw_q     <= '0;
            txr_q     <= '0;
            rxw_q     <= '0;
            rxr_q     <= '0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            rx_bit_q  <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            tx_par_q  <= 1'b0;
            tx_out_q  <= 1'b1;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            div_q     <= '0;
            rx_tc_q   <= '0;
            rx_pb_q   <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            or_q      <= 1'b0;
        end else begin
            txh_q     <= txh_d;
            rxh_q     <= rxh_d;
            txs_q     <= txs_d;
            rxs_q     <= rxs_d;
            txw_q     <= txw_d;
            txr_q     <= txr_d;
            rxw_q     <= rxw_d;
            rxr_q     <= rxr_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            rx_bit_q  <= rx_bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            tx_par_q  <= tx_par_d;
            tx_out_q  <= tx_out_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            div_q     <= div_d;
            rx_tc_q   <= rx_tc_d;
            rx_pb_q   <= rx_pb_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            or_q      <= or_d;
        end
    end

    // FIFO storage needs no reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[txw_q[FIFO_LOG2-1:0]] <= tx_data;
        if (rx_push) rx_mem[rxw_q[FIFO_LOG2-1:0]] <= rx_sh_q;
    end

    // FIFO status: equal pointers = empty, differing wrap bit = full.
    always_comb begin
        tx_head  = tx_mem[txr_q[FIFO_LOG2-1:0]];
        rx_head  = rx_mem[rxr_q[FIFO_LOG2-1:0]];
        tx_empty = (txw_q == txr_q);
        rx_empty = (rxw_q == rxr_q);
        tx_full  = (txw_q[FIFO_LOG2] != txr_q[FIFO_LOG2]) &&
                   (txw_q[FIFO_LOG2-1:0] == txr_q[FIFO_LOG2-1:0]);
        rx_full  = (rxw_q[FIFO_LOG2] != rxr_q[FIFO_LOG2]) &&
                   (rxw_q[FIFO_LOG2-1:0] == rxr_q[FIFO_LOG2-1:0]);
        tx_push  = tx_ack && (!tx_full || tx_pop);
        rx_pop   = rx_ack && !rx_empty;
        txw_d    = tx_push ? txw_q + PW'(1) : txw_q;
        txr_d    = tx_pop ? txr_q + PW'(1) : txr_q;
        rxw_d    = rx_push ? rxw_q + PW'(1) : rxw_q;
        rxr_d    = rx_pop ? rxr_q + PW'(1) : rxr_q;
    end

    // CPU handshakes: one transfer per request assertion.
    always_comb begin
        txh_d = txh_q;
        unique case (txh_q)
            HS_WAIT: if (tx_req && !tx_full) txh_d = HS_ACK;
            HS_ACK:  txh_d = HS_HOLD;
            HS_HOLD: if (!tx_req) txh_d = HS_WAIT;
            default: txh_d = HS_WAIT;
        endcase
        rxh_d = rxh_q;
        unique case (rxh_q)
            HS_WAIT: if (rx_req && !rx_empty) rxh_d = HS_ACK;
            HS_ACK:  rxh_d = HS_HOLD;
            HS_HOLD: if (!rx_req) rxh_d = HS_WAIT;
            default: rxh_d = HS_WAIT;
        endcase
        // Head is latched on entry so rx_data is valid with rx_ack.
        rx_data_d = rx_data_q;
        if (rxh_q == HS_WAIT && rxh_d == HS_ACK) rx_data_d = rx_head;
    end

    always_comb begin
        tx_ack  = (txh_q == HS_ACK);
        rx_ack  = (rxh_q == HS_ACK);
        rx_data = rx_data_q;
        tx_out  = tx_out_q;
        tx_idle = tx_empty && (txs_q == S_IDLE);
        rx_frame_err  = fe_q;
        rx_parity_err = pe_q;
        rx_over_run   = or_q;
    end

    // TX next state; a finished stop bit may reload directly.
    always_comb begin
        txs_d    = txs_q;
        tx_cnt_d = tx_cnt_q + TXW'(1);
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_par_d = tx_par_q;
        tx_pop   = 1'b0;
        load     = 1'b0;
        if (txs_q == S_IDLE) begin
            tx_cnt_d = '0;
            load     = !tx_empty;
        end else if (tx_cnt_q == TX_LAST) begin
            tx_cnt_d = '0;
            unique case (txs_q)
                S_START: begin
                    txs_d    = S_DATA;
                    tx_bit_d = '0;
                end
                S_DATA: begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == DB_LAST) begin
                        txs_d    = HAS_PAR ? S_PAR : S_STOP;
                        tx_bit_d = '0;
                    end
                end
                S_PAR: begin
                    txs_d    = S_STOP;
                    tx_bit_d = '0;
                end
                S_STOP: begin
                    if (tx_bit_q == SB_LAST) begin
                        txs_d = S_IDLE;
                        load  = !tx_empty;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
                default: txs_d = S_IDLE;
            endcase
        end
        if (load) begin
            txs_d    = S_START;
            tx_pop   = 1'b1;
            tx_cnt_d = '0;
            tx_sh_d  = tx_head;
            tx_par_d = (^tx_head) ^ ODD;
        end
    end

    // TX line is registered from the next state to stay glitch-free.
    always_comb begin
        tx_out_d = 1'b1;
        unique case (txs_d)
            S_START: tx_out_d = 1'b0;
            S_DATA:  tx_out_d = tx_sh_d[0];
            S_PAR:   tx_out_d = tx_par_d;
            default: tx_out_d = 1'b1;
        endcase
    end

    // RX next state: sample at tick 8 of start, then every 16 ticks.
    always_comb begin
        rx_meta_d = rx_in;
        rx_s_d    = rx_meta_q;
        tick      = (div_q == DV_LAST);
        div_d     = tick ? '0 : div_q + DVW'(1);
        mid       = tick && (rx_tc_q == 4'd15);
        rxs_d     = rxs_q;
        rx_tc_d   = tick ? rx_tc_q + 4'd1 : rx_tc_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_pb_d   = rx_pb_q;
        rx_push   = 1'b0;
        set_fe    = 1'b0;
        set_pe    = 1'b0;
        set_or    = 1'b0;
        unique case (rxs_q)
            S_IDLE: begin
                rx_tc_d = '0;
                if (tick && !rx_s_q) rxs_d = S_START;
            end
            S_START: begin
                if (tick && rx_tc_q == 4'd7) begin
                    rx_tc_d  = '0;
                    rx_bit_d = '0;
                    rxs_d    = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (mid) begin
                    rx_tc_d  = '0;
                    rx_sh_d  = {rx_s_q, rx_sh_q[DATA_BITS-1:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == DB_LAST)
                        rxs_d = HAS_PAR ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (mid) begin
                    rx_tc_d = '0;
                    rx_pb_d = rx_s_q;
                    rxs_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (mid) begin
                    rx_tc_d = '0;
                    if (!rx_s_q) begin
                        set_fe = 1'b1;
                        rxs_d  = S_BRK;
                    end else begin
                        rxs_d = S_IDLE;
                        if (rx_full) begin
                            set_or = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                            set_pe  = HAS_PAR &&
                                (rx_pb_q != ((^rx_sh_q) ^ ODD));
                        end
                    end
                end
            end
            S_BRK: begin
                rx_tc_d = '0;
                if (rx_s_q) rxs_d = S_IDLE;
            end
            default: rxs_d = S_IDLE;
        endcase
        // A set in the same cycle as err_clr keeps the flag.
        fe_d = set_fe || (fe_q && !err_clr);
        pe_d = set_pe || (pe_q && !err_clr);
        or_d = set_or || (or_q && !err_clr);
    end
endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered with DIV=4, 8 data bits, even parity,
// one stop bit (64-cycle bit period).
module tb_uart_buffered;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic rx_req = 1'b0;
    logic err_clr = 1'b0;
    logic rx_drv = 1'b1;
    logic loop = 1'b0;
    logic rx_in;
    logic tx_ack, tx_full, tx_idle, rx_ack, rx_empty;
    logic rx_frame_err, rx_parity_err, rx_over_run, tx_out;
    logic [7:0] rx_data;

    assign rx_in = loop ? tx_out : rx_drv;

    uart_buffered #(
        .DATA_BITS(8), .DIV(4), .PARITY(2),
        .STOP_BITS(1), .FIFO_LOG2(3)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data),
        .tx_full(tx_full), .tx_idle(tx_idle),
        .rx_req(rx_req), .rx_ack(rx_ack), .rx_data(rx_data),
        .rx_empty(rx_empty), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .rx_over_run(rx_over_run),
        .err_clr(err_clr), .rx_in(rx_in), .tx_out(tx_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } txv_t;

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       stop;
        logic       exp_empty;
        logic       exp_fe;
        logic       exp_pe;
    } rxv_t;

    txv_t txv [5];
    rxv_t rxv [5];
    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] d);
        logic got;
        got = 1'b0;
        tx_data = d;
        tx_req = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            step();
            if (tx_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk1("tx_ack_seen", got, 1'b1);
        tx_req = 1'b0;
    endtask

    task automatic rx_read(input logic [7:0] exp);
        logic got;
        got = 1'b0;
        rx_req = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (rx_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk1("rx_ack_seen", got, 1'b1);
        chk8("rx_data", rx_data, exp);
        rx_req = 1'b0;
        step();
        step();
    endtask

    task automatic wait_tx_idle(input int budget);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (tx_idle) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk1("tx_idle_reached", got, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip,
                              input logic stop);
        logic [10:0] f;
        f = {stop, (^d) ^ flip, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            rx_drv = f[b];
            repeat (64) step();
        end
        rx_drv = 1'b1;
        repeat (64) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [10:0] f;
        logic ok;
        logic got;
        int n_wait;
        logic [7:0] acks;

        txv[0] = '{8'h55, 1'b0};
        txv[1] = '{8'hA3, 1'b0};
        txv[2] = '{8'h01, 1'b1};
        txv[3] = '{8'hFF, 1'b0};
        txv[4] = '{8'h80, 1'b1};

        rxv[0] = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rxv[1] = '{8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        rxv[2] = '{8'h41, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rxv[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rxv[4] = '{8'hFE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (3) step();
        reset = 1'b0;
        step();
        chk1("rst_tx_out", tx_out, 1'b1);
        chk1("rst_tx_ack", tx_ack, 1'b0);
        chk1("rst_rx_ack", rx_ack, 1'b0);
        chk8("rst_rx_data", rx_data, 8'h00);
        chk1("rst_tx_full", tx_full, 1'b0);
        chk1("rst_tx_idle", tx_idle, 1'b1);
        chk1("rst_rx_empty", rx_empty, 1'b1);
        chk1("rst_fe", rx_frame_err, 1'b0);
        chk1("rst_pe", rx_parity_err, 1'b0);
        chk1("rst_or", rx_over_run, 1'b0);

        // TX frames, cycle-exact against the expected bit pattern.
        for (int i = 0; i < 5; i++) begin
            d = txv[i].data;
            f = {1'b1, txv[i].par, d, 1'b0};
            ok = 1'b1;
            tx_write(d);
            step();
            chk1("tx_out_before_start", tx_out, 1'b1);
            step();
            for (int c = 0; c < 704; c++) begin
                if (c % 64 == 0) ok = 1'b1;
                if (tx_out !== f[c / 64]) ok = 1'b0;
                if (c == 703) chk1("tx_idle_in_stop", tx_idle, 1'b0);
                if (c % 64 == 63)
                    chk1($sformatf("tx_v%0d_bit%0d", i, c / 64), ok, 1'b1);
                step();
            end
            chk1("tx_idle_after_frame", tx_idle, 1'b1);
            chk1("tx_out_after_frame", tx_out, 1'b1);
        end

        // Fill the TX FIFO behind a busy shifter.
        tx_write(8'h11);
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            tx_write(8'h20 + 8'(k));
            step();
            step();
        end
        chk1("tx_full_after_8", tx_full, 1'b1);
        tx_data = 8'h28;
        tx_req = 1'b1;
        got = 1'b0;
        n_wait = 0;
        for (int n = 0; n < 1500; n++) begin
            step();
            if (tx_ack) begin
                got = 1'b1;
                n_wait = n;
                break;
            end
        end
        chk1("tx_ack9_seen", got, 1'b1);
        chk1("tx_ack9_waited_for_pop", n_wait > 500, 1'b1);
        acks = 8'h00;
        repeat (20) begin
            step();
            if (tx_ack) acks++;
        end
        chk8("tx_one_ack_per_req", acks, 8'h00);
        chk1("tx_full_again", tx_full, 1'b1);
        tx_req = 1'b0;
        wait_tx_idle(10000);
        chk1("tx_full_drained", tx_full, 1'b0);

        // Loopback two characters.
        loop = 1'b1;
        tx_write(8'hA3);
        step();
        step();
        tx_write(8'h00);
        step();
        step();
        wait_tx_idle(3000);
        repeat (20) step();
        loop = 1'b0;
        chk1("loop_rx_not_empty", rx_empty, 1'b0);
        rx_read(8'hA3);
        rx_read(8'h00);
        chk1("loop_rx_empty", rx_empty, 1'b1);
        chk1("loop_fe", rx_frame_err, 1'b0);
        chk1("loop_pe", rx_parity_err, 1'b0);
        chk1("loop_or", rx_over_run, 1'b0);

        // RX frame table.
        for (int i = 0; i < 5; i++) begin
            send_frame(rxv[i].data, rxv[i].flip, rxv[i].stop);
            chk1($sformatf("rx_v%0d_empty", i), rx_empty, rxv[i].exp_empty);
            chk1($sformatf("rx_v%0d_fe", i), rx_frame_err, rxv[i].exp_fe);
            chk1($sformatf("rx_v%0d_pe", i), rx_parity_err, rxv[i].exp_pe);
            if (!rxv[i].exp_empty) rx_read(rxv[i].data);
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            chk1($sformatf("rx_v%0d_clr", i),
                 rx_frame_err | rx_parity_err | rx_over_run, 1'b0);
        end

        // Overrun: nine frames into an eight-deep FIFO.
        for (int k = 0; k < 9; k++) send_frame(8'h60 + 8'(k), 1'b0, 1'b1);
        chk1("or_set", rx_over_run, 1'b1);
        chk1("or_fe", rx_frame_err, 1'b0);
        chk1("or_pe", rx_parity_err, 1'b0);
        for (int k = 0; k < 8; k++) rx_read(8'h60 + 8'(k));
        chk1("or_drained", rx_empty, 1'b1);
        rx_req = 1'b1;
        acks = 8'h00;
        repeat (30) begin
            step();
            if (rx_ack) acks++;
        end
        rx_req = 1'b0;
        step();
        chk8("rx_no_ack_when_empty", acks, 8'h00);
        chk8("rx_data_held", rx_data, 8'h67);

        // Short low glitch must be rejected as a false start.
        rx_drv = 1'b0;
        repeat (12) step();
        rx_drv = 1'b1;
        repeat (1500) step();
        chk1("glitch_empty", rx_empty, 1'b1);
        chk1("glitch_fe", rx_frame_err, 1'b0);

        // Reset in the middle of a TX frame (during data bit 0 = 0).
        tx_write(8'h5A);
        repeat (100) step();
        chk1("tx_out_before_reset", tx_out, 1'b0);
        chk1("tx_busy_before_reset", tx_idle, 1'b0);
        reset = 1'b1;
        step();
        chk1("mid_rst_tx_out", tx_out, 1'b1);
        chk1("mid_rst_tx_idle", tx_idle, 1'b1);
        chk1("mid_rst_rx_empty", rx_empty, 1'b1);
        chk8("mid_rst_rx_data", rx_data, 8'h00);
        reset = 1'b0;
        repeat (100) step();
        chk1("post_rst_tx_out", tx_out, 1'b1);
        chk1("post_rst_tx_idle", tx_idle, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
